// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared constants and types for the instruction fetch unit.
package inst_fetch_pkg;
   localparam logic [31:0] NOP        = 32'h0000_0013;
   localparam int          FIFO_DEPTH = 2;
   typedef enum logic {FETCH, HALTED} state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry {pc, inst} prefetch FIFO with synchronous flush.
module fetch_fifo import inst_fetch_pkg::*; #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_flush,
   input  logic         i_push,
   input  logic [W-1:0] i_din,
   input  logic         i_pop,
   output logic [W-1:0] o_dout,
   output logic [1:0]   o_count
);
   logic [W-1:0] r_mem [FIFO_DEPTH];
   logic         r_wp;
   logic         r_rp;
   logic [1:0]   r_count;
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wp] <= i_din;
      if (rst || i_flush) begin
         r_wp    <= 1'b0;
         r_rp    <= 1'b0;
         r_count <= 2'd0;
      end else begin
         r_wp    <= r_wp ^ i_push;
         r_rp    <= r_rp ^ i_pop;
         r_count <= r_count + 2'(i_push) - 2'(i_pop);
      end
   end
   assign o_dout  = r_mem[r_rp];
   assign o_count = r_count;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: sequential instruction fetch from a 1-cycle ROM into a 2-entry
// prefetch FIFO, with redirect, halt and valid/ready handoff to the CPU.
module inst_fetch import inst_fetch_pkg::*; #(
   parameter int          ADDR_W   = 8,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_rd,
   input  logic [31:0]       imem_data,
   output logic [31:0]       inst,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [31:0]       pc,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   input  logic              halt
);
   localparam logic [31:0] PC_MASK = 32'((64'd1 << (ADDR_W + 2)) - 64'd1) & 32'hFFFF_FFFC;
   state_t      r_state;
   logic [31:0] r_fpc;
   logic [31:0] r_rd_pc;
   logic [31:0] r_last_pc;
   logic        r_inflight;
   logic        r_discard;
   logic [63:0] w_head;
   logic [1:0]  w_count;
   logic        w_valid;
   logic        w_pop;
   logic        w_rd;
   fetch_fifo #(.W(64)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (redirect),
      .i_push  (r_inflight && !r_discard),
      .i_din   ({r_rd_pc, imem_data}),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_count (w_count)
   );
   assign w_valid = !rst && w_count != 2'd0;
   assign w_pop   = w_valid && inst_ready;
   // occupancy excludes the entry leaving this cycle, so a full-rate stream never bubbles
   assign w_rd = !rst && r_state == FETCH && !halt &&
                 (w_count - 2'(w_pop) + 2'(r_inflight) < 2'(FIFO_DEPTH));
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= FETCH;
         r_fpc      <= RESET_PC & PC_MASK;
         r_inflight <= 1'b0;
         r_discard  <= 1'b0;
         r_last_pc  <= RESET_PC;
      end else begin
         r_state    <= halt ? HALTED : FETCH;
         r_fpc      <= redirect ? redirect_pc & PC_MASK : w_rd ? (r_fpc + 32'd4) & PC_MASK : r_fpc;
         r_inflight <= w_rd;
         r_discard  <= w_rd && redirect;
         if (w_valid) r_last_pc <= w_head[63:32];
      end
      if (w_rd) r_rd_pc <= r_fpc;
   end
   assign imem_rd    = w_rd;
   assign imem_addr  = rst ? '0 : r_fpc[ADDR_W+1:2];
   assign inst_valid = w_valid;
   assign inst       = w_valid ? w_head[31:0] : NOP;
   assign pc         = rst ? RESET_PC : w_valid ? w_head[63:32] : r_last_pc;
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory word-address width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, byte address fetched first after reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 imem_addr  output  ADDR_W  word address to instruction ROM (byte PC[ADDR_W+1:2]).
REQ-006 imem_rd  output  1  read strobe; ROM returns data exactly one cycle later.
REQ-007 imem_data  input  32  ROM read data, valid in the cycle after imem_rd.
REQ-008 inst  output  32  instruction presented to the CPU `inst` port.
REQ-009 inst_valid  output  1  inst/pc hold a valid instruction.
REQ-010 inst_ready  input  1  CPU accepts; transfer occurs when inst_valid && inst_ready.
REQ-011 pc  output  32  byte address of inst.
REQ-012 redirect  input  1  one-cycle pulse; refetch from redirect_pc.
REQ-013 redirect_pc  input  32  redirect target byte address; bits [1:0] ignored.
REQ-014 halt  input  1  level; while high no new reads are issued.

Function
REQ-015 Fetch PC shall advance by 4 per issued read, wrapping modulo 2^(ADDR_W+2) with no error.
REQ-016 A 2-entry prefetch FIFO shall hold {pc, inst}; imem_rd shall assert only when FIFO count + reads in flight < 2, and halt is low.
REQ-017 Returned imem_data shall be written to the FIFO at the end of the cycle it is valid, unless marked discard.
REQ-018 inst_valid shall equal FIFO-not-empty; inst/pc shall be the FIFO head.
REQ-019 While inst_valid && !inst_ready, inst and pc shall remain stable.
REQ-020 When inst_valid is low, inst shall read 32'h0000_0013 (NOP) and pc shall hold its last value.
REQ-021 Latency: first cycle with rst low = cycle 0: imem_rd=1 at RESET_PC; inst_valid=1 in cycle 2.
REQ-022 With inst_ready held high and halt low, one instruction shall transfer every cycle from cycle 2 onward.
REQ-023 Redirect in cycle k: FIFO flushed at end of k; any read in flight marked discard; cycle k+1 imem_rd=1 at redirect_pc; inst_valid low in k+1 and k+2, high in k+3.
REQ-024 Redirect and transfer in the same cycle: the transfer completes, then the flush applies.
REQ-025 Redirect while halt is high: fetch PC updated and FIFO flushed; no read issued until halt falls.
REQ-026 FSM states FETCH and HALTED: FETCH->HALTED when halt=1; HALTED->FETCH when halt=0; in HALTED the in-flight response is still captured and the FIFO drains normally.
REQ-027 FIFO full with inst_ready low shall never drop or overwrite an entry.

Reset
REQ-028 While rst=1: imem_rd=0, imem_addr=0, inst_valid=0, inst=32'h0000_0013, pc=RESET_PC, FIFO empty, discard cleared, FSM=FETCH, fetch PC=RESET_PC.
REQ-029 rst asserted mid-operation shall drop in-flight reads and FIFO contents in that same cycle's update.

Structure
REQ-030 Shared package holds NOP encoding, FSM state typedef, and FIFO depth constant (2).
REQ-031 One sub-module: fetch_fifo (2-entry synchronous FIFO, {pc,inst} payload, flush input).

Verification
REQ-032 Reset release, ROM[n]=n+0x100, inst_ready=1 -> cycle 2 inst=0x100 pc=0, cycle 3 inst=0x101 pc=4, one per cycle.
REQ-033 inst_ready=0 for 5 cycles from cycle 2 -> inst=0x100 held, imem_rd stops after 2 outstanding, no loss after ready rises.
REQ-034 redirect=1, redirect_pc=0x40 in cycle 4 -> k+1 imem_addr=0x10, inst_valid low k+1..k+2, k+3 pc=0x40 inst=ROM[0x10].
REQ-035 Start at PC 0x3FC (ADDR_W=8) -> next pc=0x000, imem_addr wraps 0xFF->0x00.
REQ-036 halt=1 for 4 cycles with inst_ready=1 -> FIFO drains, inst_valid falls, NOP on inst; halt=0 resumes at next sequential pc.
REQ-037 rst=1 for one cycle while FIFO full -> next cycle inst_valid=0, pc=RESET_PC; refetch from RESET_PC per REQ-021.
